// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style bus responder.
// Holds instruction bit positions, error bit positions, the FSM state enum,
// DDRAM address constants, the address-to-cell mapping and the address-counter
// wrap function.
package lcd_pkg;

    // Instruction opcode is identified by its highest set bit
    localparam int INS_SET_DDRAM = 7;
    localparam int INS_SET_CGRAM = 6;
    localparam int INS_FUNC_SET  = 5;
    localparam int INS_SHIFT     = 4;
    localparam int INS_DISP_CTRL = 3;
    localparam int INS_ENTRY     = 2;
    localparam int INS_HOME      = 1;
    localparam int INS_CLEAR     = 0;

    localparam int FUNC_DL_BIT   = 4;
    localparam int ENTRY_ID_BIT  = 1;

    // Sticky error vector layout: {rw_err, overrun, proto_err}
    localparam int ERR_RW        = 2;
    localparam int ERR_OVERRUN   = 1;
    localparam int ERR_PROTO     = 0;

    localparam logic [7:0] LCD_SPACE  = 8'h20;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] FRAME_END  = 7'h4F;

    localparam int NUM_CELLS = 32;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_UNINIT = 2'd1,
        S_READY  = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } cell_sel_t;

    // Only the first 16 addresses of each line are backed by a cell.
    function automatic cell_sel_t lcd_addr_to_cell(input logic [6:0] a);
        cell_sel_t c;
        c.hit = 1'b0;
        c.idx = '0;
        if (a[6:4] == LINE0_BASE[6:4]) begin
            c.hit = 1'b1;
            c.idx = {1'b0, a[3:0]};
        end else if (a[6:4] == LINE1_BASE[6:4]) begin
            c.hit = 1'b1;
            c.idx = {1'b1, a[3:0]};
        end
        return c;
    endfunction

    // Address counter step: each line holds 40 positions, lines chain into each other.
    function automatic logic [6:0] lcd_next_addr(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            case (a)
                7'h27:   n = LINE1_BASE;
                7'h67:   n = LINE0_BASE;
                default: n = a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h00:   n = 7'h67;
                7'h40:   n = 7'h27;
                default: n = a - 7'd1;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// lcd_bus_responder_if: character-LCD parallel bus.
//   lcd_rs   register select (0 = instruction, 1 = data)
//   lcd_rw   read/write (only writes are legal)
//   lcd_en   enable strobe, transfer taken on its falling edge
//   lcd_data 8-bit bus data
// master = the LCD controller, slave = the responder.
interface lcd_bus_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
    modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32x8 display data RAM image.
//   clk, reset       clock, sync active-high reset (read register only)
//   we/waddr/wdata   single write port
//   raddr/rdata      synchronous read port, 1-cycle latency, read-before-write
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [NUM_CELLS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: receive-side model of an HD44780-style character LCD.
// Synchronizes the bus, latches each transfer on the falling edge of lcd_en,
// decodes instructions and keeps a 2x16 DDRAM image plus display-mode state.
//   clk, reset    clock, synchronous active-high reset
//   bus           LCD bus (slave modport)
//   rd_idx        cell index for the side read port (0-15 line 0, 16-31 line 1)
//   rd_data       character at rd_idx, 1-cycle latency
//   addr          DDRAM address counter
//   disp_ctrl     {D, C, B} from the last display-control instruction
//   entry_id      entry-mode increment (1) / decrement (0)
//   initialized   set by a function set with DL=1
//   busy          clear fill in progress
//   frame_done    pulse when a data write lands at 0x4F
//   err           sticky {rw_err, overrun, proto_err}
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_bus_responder_if.slave    bus,
    input  logic [4:0]            rd_idx,
    output logic [7:0]            rd_data,
    output logic [6:0]            addr,
    output logic [2:0]            disp_ctrl,
    output logic                  entry_id,
    output logic                  initialized,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            err
);

    lcd_state_e state;
    logic [4:0] clr_idx;

    // ---- stage p0: input synchronizers ----
    logic [SYNC_STAGES-1:0] en_p0;
    logic [SYNC_STAGES-1:0] rs_p0;
    logic [SYNC_STAGES-1:0] rw_p0;
    logic [7:0]             data_p0 [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            en_p0 <= '0;
        end else begin
            en_p0 <= {en_p0[SYNC_STAGES-2:0], bus.lcd_en};
        end
    end

    always_ff @(posedge clk) begin
        rs_p0      <= {rs_p0[SYNC_STAGES-2:0], bus.lcd_rs};
        rw_p0      <= {rw_p0[SYNC_STAGES-2:0], bus.lcd_rw};
        data_p0[0] <= bus.lcd_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_p0[i] <= data_p0[i-1];
        end
    end

    logic       en_sync;
    logic       rs_sync;
    logic       rw_sync;
    logic [7:0] data_sync;

    assign en_sync   = en_p0[SYNC_STAGES-1];
    assign rs_sync   = rs_p0[SYNC_STAGES-1];
    assign rw_sync   = rw_p0[SYNC_STAGES-1];
    assign data_sync = data_p0[SYNC_STAGES-1];

    // ---- stage p1: falling-edge detect on en ----
    logic en_prev_p1;
    logic vld_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_prev_p1 <= 1'b0;
        end else begin
            en_prev_p1 <= en_sync;
        end
    end

    // rs/data are taken from the synchronized copies in the strobe cycle
    assign vld_p1 = en_prev_p1 & ~en_sync;

    // ---- stage p2: DDRAM write port (clear fill or data write) ----
    cell_sel_t  cell_c;
    logic       we_c;
    logic [4:0] waddr_c;
    logic [7:0] wdata_c;

    assign cell_c = lcd_addr_to_cell(addr);

    always_comb begin
        we_c    = 1'b0;
        waddr_c = clr_idx;
        wdata_c = LCD_SPACE;
        if (state == S_CLEAR) begin
            we_c = 1'b1;
        end else if (state == S_READY && vld_p1 && !rw_sync && rs_sync && cell_c.hit) begin
            we_c    = 1'b1;
            waddr_c = cell_c.idx;
            wdata_c = data_sync;
        end
    end

    lcd_ddram u_ddram (
        .clk   (clk),
        .reset (reset),
        .we    (we_c),
        .waddr (waddr_c),
        .wdata (wdata_c),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign busy = (state == S_CLEAR);

    // ---- stage p2: decode / control state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CLEAR;
            clr_idx     <= '0;
            addr        <= LINE0_BASE;
            disp_ctrl   <= '0;
            entry_id    <= 1'b1;
            initialized <= 1'b0;
            frame_done  <= 1'b0;
            err         <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (vld_p1) begin
                        err[ERR_OVERRUN] <= 1'b1;
                    end
                    if (clr_idx == 5'(NUM_CELLS - 1)) begin
                        clr_idx  <= '0;
                        addr     <= LINE0_BASE;
                        entry_id <= 1'b1;
                        state    <= initialized ? S_READY : S_UNINIT;
                    end else begin
                        clr_idx <= clr_idx + 5'd1;
                    end
                end
                default: begin
                    if (vld_p1) begin
                        if (rw_sync) begin
                            err[ERR_RW] <= 1'b1;
                        end else if (!rs_sync) begin
                            if (data_sync[INS_SET_DDRAM]) begin
                                addr <= data_sync[6:0];
                            end else if (data_sync[INS_SET_CGRAM]) begin
                                err[ERR_PROTO] <= 1'b1;
                            end else if (data_sync[INS_FUNC_SET]) begin
                                initialized <= data_sync[FUNC_DL_BIT];
                            end else if (data_sync[INS_SHIFT]) begin
                                // cursor/display shift has no effect on the image
                            end else if (data_sync[INS_DISP_CTRL]) begin
                                disp_ctrl <= data_sync[2:0];
                            end else if (data_sync[INS_ENTRY]) begin
                                entry_id <= data_sync[ENTRY_ID_BIT];
                            end else if (data_sync[INS_HOME]) begin
                                addr <= LINE0_BASE;
                            end else if (data_sync[INS_CLEAR]) begin
                                clr_idx <= '0;
                                state   <= S_CLEAR;
                            end
                        end else if (state == S_UNINIT) begin
                            err[ERR_PROTO] <= 1'b1;
                        end else begin
                            // counter steps even when the address has no backing cell
                            addr <= lcd_next_addr(addr, entry_id);
                            if (cell_c.hit && addr == FRAME_END) begin
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rd_idx;
    logic [7:0] rd_data;
    logic [6:0] addr;
    logic [2:0] disp_ctrl;
    logic       entry_id;
    logic       initialized;
    logic       busy;
    logic       frame_done;
    logic [2:0] err;

    always #5 clk = ~clk;

    lcd_bus_responder_if bus_if ();

    lcd_bus_responder #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .addr        (addr),
        .disp_ctrl   (disp_ctrl),
        .entry_id    (entry_id),
        .initialized (initialized),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;
    int fd_cnt   = 0;

    // Reference model state
    logic [7:0] m_cell [32];
    int         m_addr;
    bit         m_id;
    bit         m_init;
    bit         m_ready;
    logic [2:0] m_disp;
    logic [2:0] m_err;
    int         m_fd;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int a);
        if (a >= 0 && a < 16) return a;
        if (a >= 64 && a < 80) return a - 64 + 16;
        return -1;
    endfunction

    function automatic int m_next(input int a, input bit inc);
        if (inc) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    task automatic model_clear_cells();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_addr = 0;
        m_id   = 1'b1;
    endtask

    task automatic model_strobe(input bit rs, input bit rw, input logic [7:0] d, input bit busy_now);
        int idx;
        if (busy_now) begin
            m_err[1] = 1'b1;
            return;
        end
        if (rw) begin
            m_err[2] = 1'b1;
            return;
        end
        if (!rs) begin
            if (d >= 8'd128)     m_addr = int'(d) - 128;
            else if (d >= 8'd64) m_err[0] = 1'b1;
            else if (d >= 8'd32) m_init = d[4];
            else if (d >= 8'd16) m_addr = m_addr;
            else if (d >= 8'd8)  m_disp = d[2:0];
            else if (d >= 8'd4)  m_id = d[1];
            else if (d >= 8'd2)  m_addr = 0;
            else if (d == 8'd1) begin
                model_clear_cells();
                m_ready = m_init;
            end
        end else if (!m_ready) begin
            m_err[0] = 1'b1;
        end else begin
            idx = m_idx(m_addr);
            if (idx >= 0) m_cell[idx] = d;
            if (m_addr == 79) m_fd++;
            m_addr = m_next(m_addr, m_id);
        end
    endtask

    task automatic pulse(input bit rs, input bit rw, input logic [7:0] d, input int post);
        bus_if.lcd_rs   = rs;
        bus_if.lcd_rw   = rw;
        bus_if.lcd_data = d;
        bus_if.lcd_en   = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.lcd_en   = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        pulse(rs, rw, d, 6);
        model_strobe(rs, rw, d, 1'b0);
        if (!rs && !rw && d == 8'h01) repeat (40) @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".addr"},      32'(addr),        32'(m_addr));
        chk({tag, ".disp"},      32'(disp_ctrl),   32'(m_disp));
        chk({tag, ".entry_id"},  32'(entry_id),    32'(m_id));
        chk({tag, ".init"},      32'(initialized), 32'(m_init));
        chk({tag, ".err"},       32'(err),         32'(m_err));
        chk({tag, ".busy"},      32'(busy),        32'd0);
        chk({tag, ".frames"},    32'(fd_cnt),      32'(m_fd));
    endtask

    task automatic check_cells(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            @(negedge clk);
            chk($sformatf("%s.cell%0d", tag, i), 32'(rd_data), 32'(m_cell[i]));
        end
    endtask

    initial begin
        string      s1;
        string      s2;
        int         n;
        int         r;
        int         a;
        logic [7:0] ch;

        s1 = "CLOCK V01: KWS  ";
        s2 = "Hello, world 123";

        reset           = 1'b1;
        rd_idx          = '0;
        bus_if.lcd_rs   = 1'b0;
        bus_if.lcd_rw   = 1'b0;
        bus_if.lcd_en   = 1'b0;
        bus_if.lcd_data = '0;
        repeat (3) @(negedge clk);

        chk("rst.addr",    32'(addr),        32'h0);
        chk("rst.disp",    32'(disp_ctrl),   32'h0);
        chk("rst.id",      32'(entry_id),    32'h1);
        chk("rst.init",    32'(initialized), 32'h0);
        chk("rst.frame",   32'(frame_done),  32'h0);
        chk("rst.err",     32'(err),         32'h0);
        chk("rst.rd_data", 32'(rd_data),     32'h0);
        chk("rst.busy",    32'(busy),        32'h1);

        model_clear_cells();
        m_init  = 1'b0;
        m_ready = 1'b0;
        m_disp  = '0;
        m_err   = '0;
        m_fd    = 0;

        // Clear fill after reset: busy for exactly 32 cycles
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", 32'(n), 32'd32);
        check_regs("post_reset");
        check_cells("post_reset");

        // Data write before initialization is dropped
        send(1'b1, 1'b0, 8'h41);
        chk("uninit.proto", 32'(err[0]), 32'h1);
        check_regs("uninit");
        check_cells("uninit");

        // Init sequence and line 0
        send(1'b0, 1'b0, 8'h38);
        send(1'b0, 1'b0, 8'h01);
        send(1'b0, 1'b0, 8'h0C);
        send(1'b0, 1'b0, 8'h06);
        send(1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, s1[i]);
        chk("line0.init", 32'(initialized), 32'h1);
        chk("line0.disp", 32'(disp_ctrl),   32'h4);
        chk("line0.addr", 32'(addr),        32'h10);
        check_regs("line0");
        check_cells("line0");

        // Line 1, frame_done on the 0x4F write
        send(1'b0, 1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 1'b0, s2[i]);
            if (i == 14) chk("line1.no_early_frame", 32'(fd_cnt), 32'd0);
        end
        chk("line1.frames", 32'(fd_cnt), 32'd1);
        chk("line1.addr",   32'(addr),   32'h50);
        check_regs("line1");
        check_cells("line1");

        // Decrement mode wraps
        send(1'b0, 1'b0, 8'h04);
        send(1'b0, 1'b0, 8'h80);
        send(1'b1, 1'b0, 8'h41);
        chk("dec.id",    32'(entry_id), 32'h0);
        chk("dec.wrap0", 32'(addr),     32'h67);
        send(1'b0, 1'b0, 8'hC0);
        send(1'b1, 1'b0, 8'h42);
        chk("dec.wrap1", 32'(addr),     32'h27);
        check_regs("dec");
        check_cells("dec");

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                ch = 8'($urandom_range(32, 126));
                send(1'b1, 1'b0, ch);
            end else if (r <= 7) begin
                case ($urandom_range(0, 3))
                    0:       a = $urandom_range(0, 15);
                    1:       a = 64 + $urandom_range(0, 15);
                    2:       a = $urandom_range(0, 127);
                    default: begin
                        case ($urandom_range(0, 5))
                            0:       a = 8'h27;
                            1:       a = 8'h67;
                            2:       a = 8'h00;
                            3:       a = 8'h40;
                            4:       a = 8'h0F;
                            default: a = 8'h4F;
                        endcase
                    end
                endcase
                send(1'b0, 1'b0, 8'h80 | 8'(a));
            end else if (r == 8) begin
                send(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)));
            end else begin
                send(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)));
            end
            chk($sformatf("rand%0d.addr", k), 32'(addr), 32'(m_addr));
        end
        check_regs("rand");
        check_cells("rand");

        // Read strobe is rejected
        send(1'b1, 1'b1, 8'h5A);
        chk("rw.err", 32'(err[2]), 32'h1);
        check_regs("rw");

        // Strobe during a clear fill is an overrun
        pulse(1'b0, 1'b0, 8'h01, 2);
        model_strobe(1'b0, 1'b0, 8'h01, 1'b0);
        pulse(1'b1, 1'b0, 8'h55, 2);
        model_strobe(1'b1, 1'b0, 8'h55, 1'b1);
        repeat (45) @(negedge clk);
        chk("overrun.err", 32'(err[1]), 32'h1);
        check_regs("overrun");
        check_cells("overrun");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
